// File: rtl/image_pkg.sv
// Shared widths and geometry for the Bayer-to-greyscale path.
package image_pkg;
  localparam int unsigned LINE_WIDTH = 1280;
  localparam int unsigned DATA_W     = 12;
  localparam int unsigned CNT_W      = 11;
  localparam int unsigned SUM_W      = DATA_W + 2;
endpackage

// File: rtl/line_buffer.sv
// One row of raw samples; combinational read of the old entry, write on the clock edge.
module line_buffer
  import image_pkg::*;
#(
  parameter int unsigned DEPTH  = LINE_WIDTH,
  parameter int unsigned WIDTH  = DATA_W,
  parameter int unsigned ADDR_W = CNT_W
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  output logic [WIDTH-1:0]  rdata_o
);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             addr_ok;

  assign addr_ok = (addr_i <= ADDR_LAST);

  // Read-before-write: the read sees the entry from the previous row.
  always_comb begin
    rdata_o = '0;
    if (addr_ok) rdata_o = mem_q[addr_i];
  end

  always_ff @(posedge clk_i) begin
    if (we_i && addr_ok) mem_q[addr_i] <= wdata_i;
  end
endmodule

// File: rtl/image_processing.sv
// Bayer-to-grey: averages each 2x2 quad, one-cycle registered output on odd row/odd column.
module image_processing
  import image_pkg::*;
#(
  parameter int unsigned LINE_WIDTH = image_pkg::LINE_WIDTH,
  parameter int unsigned DATA_W     = image_pkg::DATA_W
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [CNT_W-1:0]  iX_Cont,
  input  logic [CNT_W-1:0]  iY_Cont,
  input  logic [DATA_W-1:0] iDATA,
  input  logic              iDVAL,
  output logic [DATA_W-1:0] oRed,
  output logic [DATA_W-1:0] oGreen,
  output logic [DATA_W-1:0] oBlue,
  output logic              oDVAL
);
  localparam int unsigned       SW     = DATA_W + 2;
  localparam logic [CNT_W-1:0]  X_LAST = CNT_W'(LINE_WIDTH - 1);

  logic [DATA_W-1:0] buf_rd;
  logic [DATA_W-1:0] cur_q, cur_d;
  logic [DATA_W-1:0] up_q, up_d;
  logic [DATA_W-1:0] grey_q, grey_d;
  logic              dval_q, dval_d;
  logic [SW-1:0]     sum;
  logic              x_ok;
  logic              quad;

  assign x_ok = (iX_Cont <= X_LAST);

  line_buffer #(
    .DEPTH  (LINE_WIDTH),
    .WIDTH  (DATA_W),
    .ADDR_W (CNT_W)
  ) u_line_buffer (
    .clk_i   (iCLK),
    .we_i    (iDVAL && x_ok),
    .addr_i  (iX_Cont),
    .wdata_i (iDATA),
    .rdata_o (buf_rd)
  );

  always_comb begin
    sum    = SW'(up_q) + SW'(buf_rd) + SW'(cur_q) + SW'(iDATA);
    quad   = iDVAL && x_ok && iX_Cont[0] && iY_Cont[0];
    cur_d  = cur_q;
    up_d   = up_q;
    grey_d = grey_q;
    dval_d = quad;
    if (iDVAL) begin
      cur_d = iDATA;
      up_d  = buf_rd;
    end
    if (quad) grey_d = sum[SW-1:2];
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      cur_q  <= '0;
      up_q   <= '0;
      grey_q <= '0;
      dval_q <= 1'b0;
    end else begin
      cur_q  <= cur_d;
      up_q   <= up_d;
      grey_q <= grey_d;
      dval_q <= dval_d;
    end
  end

  assign oBlue  = grey_q;
  assign oRed   = grey_q;
  assign oGreen = grey_q;
  assign oDVAL  = dval_q;
endmodule

// File: tb/tb_image_processing.sv
// Scoreboard bench for image_processing: driver queues expected quads, monitor checks pulses.
module tb_image_processing;
  localparam int LW = 1280;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [10:0] x_in = '0;
  logic [10:0] y_in = '0;
  logic [11:0] d_in = '0;
  logic        dval_in = 1'b0;
  logic [11:0] o_r, o_g, o_b;
  logic        o_dval;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulses = 0;

  logic [11:0] exp_q[$];
  int          exp_cyc_q[$];

  image_processing #(.LINE_WIDTH(LW), .DATA_W(12)) dut (
    .iCLK(clk), .iRST(rst), .iX_Cont(x_in), .iY_Cont(y_in),
    .iDATA(d_in), .iDVAL(dval_in),
    .oRed(o_r), .oGreen(o_g), .oBlue(o_b), .oDVAL(o_dval)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [11:0] pat(input int x, input int y);
    pat = 12'((x ^ y) & 32'hFFF);
  endfunction

  function automatic logic [11:0] pat_mean(input int x, input int y);
    int s;
    s = pat(x-1, y-1) + pat(x, y-1) + pat(x-1, y) + pat(x, y);
    pat_mean = 12'(s >> 2);
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every output pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (o_dval === 1'b1) begin
      pulses++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got pulse at cycle %0d expected none", cyc);
      end else begin
        logic [11:0] e;
        int          ec;
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("pulse_cycle", cyc, ec);
        check("oBlue", o_b, e);
        check("oRed", o_r, e);
        check("oGreen", o_g, e);
      end
    end
  end

  task automatic px(input int x, input int y, input logic [11:0] d,
                    input bit push, input logic [11:0] e);
    x_in = 11'(x); y_in = 11'(y); d_in = d; dval_in = 1'b1;
    if (push) begin
      exp_q.push_back(e);
      exp_cyc_q.push_back(cyc + 1);
    end
    @(posedge clk); #1;
    dval_in = 1'b0;
  endtask

  task automatic idle(input int n);
    dval_in = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Pattern or saturated row; optional 3-cycle iDVAL gap between x=4 and x=5.
  task automatic row(input int y, input bit sat, input bit gap);
    logic [11:0] e;
    bit          q;
    for (int x = 0; x < LW; x++) begin
      if (gap && x == 5) idle(3);
      q = (y % 2 == 1) && (x % 2 == 1);
      if (sat)                            e = 12'hFFF;
      else if (y == 1 && x == 1)          e = 12'h000;
      else if (y == 1 && x == 3)          e = 12'h002;
      else if (y == 1 && x == 5 && gap)   e = 12'h004;
      else                                e = pat_mean(x, y);
      px(x, y, sat ? 12'hFFF : pat(x, y), q, e);
    end
    idle(2);
  endtask

  initial begin
    int p0;
    #1;
    // Reset held with valid odd/odd input: nothing may come out.
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      x_in = 11'd1; y_in = 11'd1; d_in = 12'hFFF; dval_in = 1'b1;
      @(posedge clk); #1;
      check("reset_dval", o_dval, 0);
      check("reset_blue", o_b, 0);
    end
    rst = 1'b0; dval_in = 1'b0;
    @(posedge clk); #1;
    check("post_reset_dval", o_dval, 0);
    check("post_reset_blue", o_b, 0);

    // Full pattern frame, per-row pulse counts.
    for (int y = 0; y < 4; y++) begin
      p0 = pulses;
      row(y, 1'b0, 1'b0);
      check($sformatf("row%0d_pulses", y), pulses - p0, (y % 2 == 1) ? 640 : 0);
    end

    // Saturation.
    p0 = pulses;
    row(0, 1'b1, 1'b0);
    row(1, 1'b1, 1'b0);
    check("sat_pulses", pulses - p0, 640);

    // Gap inside row 1.
    row(0, 1'b0, 1'b0);
    row(1, 1'b0, 1'b1);

    // Reset pulse in the middle of row 1.
    row(0, 1'b0, 1'b0);
    for (int x = 0; x < 110; x++) begin
      if (x == 101) begin
        rst = 1'b1;
        px(x, 1, pat(x, 1), 1'b0, 12'h000);
        rst = 1'b0;
        check("midreset_dval", o_dval, 0);
        check("midreset_blue", o_b, 0);
      end else begin
        px(x, 1, pat(x, 1), (x % 2 == 1),
           (x == 103) ? 12'h066 : pat_mean(x, 1));
      end
    end
    idle(4);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1);
  end
endmodule

// File: doc/image_processing.md
Name: image_processing

Overview:
- Bayer-to-greyscale converter for the DE1-SoC camera pipeline; sits between the raw CCD capture stage and the RGB/VGA output path.
- Accepts one 12-bit raw Bayer pixel per valid cycle, tagged with column/row counters.
- For each complete 2x2 Bayer quad it emits one 12-bit grey value: the mean of the four samples.
- Uses a one-line buffer to pair the current row with the previous one.

Parameters:
- LINE_WIDTH, 1280, pixels per row; sets line-buffer depth and the valid iX_Cont range.
- DATA_W, 12, raw and grey sample width.

Ports:
- iCLK  in  1  single system clock; all logic on rising edge.
- iRST  in  1  reset, synchronous, active-high.
- iX_Cont  in  11  column index of the current pixel, 0..LINE_WIDTH-1.
- iY_Cont  in  11  row index of the current pixel.
- iDATA  in  12  raw Bayer sample.
- iDVAL  in  1  input pixel valid.
- oRed  out  12  grey value (duplicate of oBlue).
- oGreen  out  12  grey value (duplicate of oBlue).
- oBlue  out  12  grey value.
- oDVAL  out  1  output valid; one-cycle pulse per completed quad.

Behaviour:
- Reset (iRST=1 at a clock edge): oRed/oGreen/oBlue=0, oDVAL=0, previous-pixel register=0, previous-row-pixel register=0.
- Line buffer contents are not cleared by reset.
- Line buffer: LINE_WIDTH x 12, indexed by iX_Cont.
  - Each cycle with iDVAL=1: read the entry at iX_Cont (previous row's sample, read-before-write), then write iDATA at iX_Cont.
  - No writes when iDVAL=0.
- Delay registers, updated only when iDVAL=1:
  - cur_d ← iDATA
  - up_d ← line-buffer read data
- Quad complete condition: iDVAL=1 AND iX_Cont[0]=1 AND iY_Cont[0]=1.
- Quad samples: P(x-1,y-1)=up_d, P(x,y-1)=buffer read, P(x-1,y)=cur_d, P(x,y)=iDATA.
- Arithmetic:
  - sum = zero-extended 14-bit sum of the four samples (no overflow possible).
  - grey = sum[13:2], i.e. truncating divide by 4.
- Latency: one cycle. On the edge after a quad-complete cycle, oBlue/oRed/oGreen=grey and oDVAL=1.
- Every other cycle: oDVAL=0 and the grey outputs hold their last value.
- Even rows (iY_Cont[0]=0) never produce output; they only fill the buffer.
- Row 0 output uses whatever the buffer holds, so the first quad row is valid only from row 1 onward, which is always the case since output occurs on odd rows.
- Gaps: iDVAL may drop mid-row or between rows. Registers and buffer freeze; no output is produced.
- Out-of-range iX_Cont (≥LINE_WIDTH): no buffer write, no output.
- Reset mid-row: outputs clear next edge; processing resumes on the next valid pixel.

Decomposition:
- Shared package image_pkg holds LINE_WIDTH, DATA_W, the counter width (11), and the sum width (DATA_W+2).
- One natural sub-module: line_buffer, a single-port read-before-write RAM of LINE_WIDTH x DATA_W with synchronous write and combinational read, inferable as block RAM.
- Top level contains the delay registers, adder tree and output registers.

Test Plan:
- Reset: assert iRST=1 for 2 cycles with iDVAL=1 → oDVAL=0 and oBlue=0 throughout and one cycle after release.
- Pattern: iDATA=(x^y)&0xFFF over rows 0..3 of 1280 px with 2 idle cycles between rows.
  - Row 1, x=1 → oDVAL pulse with oBlue=0x000 (0+1+1+0=2, truncated).
  - Row 1, x=3 → oBlue=0x002 (2+3+3+2=10).
  - Rows 0 and 2 produce no oDVAL pulses.
- Saturation: all pixels 0xFFF for 2 rows → every odd-x pulse on row 1 gives oBlue=0xFFF, and oRed=oGreen=oBlue.
- Count check: a full 1280x4 frame → exactly 1280 oDVAL pulses (640 per odd row), each exactly one cycle after the odd-x input.
- Gap handling: on row 1, deassert iDVAL for 3 cycles between x=4 and x=5 → x=5 output still equals the mean of P(4,0), P(5,0), P(4,1), P(5,1); no pulse during the gap.
- Mid-row reset: pulse iRST during row 1 at x=101 → no pulse for x=101, outputs=0; the pulse at x=103 is correct.
